// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the multiply sequencer
// that borrows it.
//   ALU_OP_RTYPE / ALU_FN_ADD : operation the sequencer presents to the ALU
//   mul_state_t               : multiply sequencer states
package alu_pkg;

  localparam logic [4:0] ALU_OP_RTYPE = 5'b11011;
  localparam logic [1:0] ALU_FN_ADD   = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/grant bundle between the multiply sequencer and the execute-stage
// ALU mux.
//   alu_req    : sequencer wants the ALU this cycle
//   alu_gnt    : mux routes sequencer operands this cycle
//   alu_opcode : operation opcode (R-type)
//   alu_funct  : operation function (ADD)
//   alu_rs     : first operand (accumulator)
//   alu_rt     : second operand (shifted multiplicand)
//   alu_res    : combinational ALU result, valid with alu_gnt
interface mul_seq_if #(parameter int WIDTH = 16);

  logic             alu_req;
  logic             alu_gnt;
  logic [4:0]       alu_opcode;
  logic [1:0]       alu_funct;
  logic [WIDTH-1:0] alu_rs;
  logic [WIDTH-1:0] alu_rt;
  logic [WIDTH-1:0] alu_res;

  modport master (
    output alu_req, alu_opcode, alu_funct, alu_rs, alu_rt,
    input  alu_gnt, alu_res
  );

  modport slave (
    input  alu_req, alu_opcode, alu_funct, alu_rs, alu_rt,
    output alu_gnt, alu_res
  );

endinterface

// File: rtl/mul_seq_dp.sv
// Shift-and-add datapath for the multiply sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   load_en    : load a/b, clear accumulator and iteration count
//   step_en    : complete one iteration (optional add, then shift)
//   add_en     : take alu_res into the accumulator on this iteration
//   a, b       : operands captured on load
//   alu_res    : shared ALU result
//   acc, mcand, mplier : current register values
//   acc_nxt    : accumulator value after this edge
//   last_iter  : the iteration in progress is the final one
module mul_seq_dp #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic             step_en,
  input  logic             add_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] acc_nxt,
  output logic             last_iter
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_en) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
    end else if (step_en) begin
      if (add_en) acc_d = alu_res;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Post-shift multiplier is zero exactly when all bits above bit 0 are zero.
  assign last_iter = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc     = acc_q;
  assign mcand   = mcand_q;
  assign mplier  = mplier_q;
  assign acc_nxt = acc_d;

endmodule

// File: rtl/mul_seq.sv
// Iterative multiply sequencer that borrows the execute-stage ALU for each
// addition through a request/grant handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a multiply (sampled only when idle)
//   a, b       : multiplicand / multiplier, captured with start
//   busy       : operation in progress (RUN or DONE)
//   done       : one-cycle pulse, product valid
//   product    : low WIDTH bits of a*b, held until the next product
//   alu        : ALU request/grant bundle (master side)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-and-add iteration per cycle, stalls while ALU denied
// DONE  | product registered, done pulse
module mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  mul_seq_if.master        alu
);
  import alu_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             load_en, step_en, add_en, last_iter;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_nxt;

  mul_seq_dp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .step_en   (step_en),
    .add_en    (add_en),
    .a         (a),
    .b         (b),
    .alu_res   (alu.alu_res),
    .acc       (acc),
    .mcand     (mcand),
    .mplier    (mplier),
    .acc_nxt   (acc_nxt),
    .last_iter (last_iter)
  );

  // An iteration that needs an add completes only when the ALU is granted.
  assign add_en  = mplier[0];
  assign step_en = (state_q == ST_RUN) && (!mplier[0] || alu.alu_gnt);

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_en = 1'b1;
          state_d = ((a == '0) || (b == '0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN:  if (step_en && last_iter) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the accumulator as it will be after this edge, so the final add
  // (or the zero-operand clear) lands in product on DONE entry.
  always_comb begin
    product_d = product_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) product_d = acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

  assign alu.alu_req    = (state_q == ST_RUN) && mplier[0];
  assign alu.alu_opcode = ALU_OP_RTYPE;
  assign alu.alu_funct  = ALU_FN_ADD;
  assign alu.alu_rs     = acc;
  assign alu.alu_rt     = mcand;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy, done;
  logic [W-1:0] product;
  logic         gnt = 1'b0;

  mul_seq_if #(.WIDTH(W)) alu_if ();

  // Bench plays the ALU: adds the operands when granted, garbage otherwise.
  assign alu_if.alu_gnt = gnt;
  assign alu_if.alu_res = gnt ? 16'(alu_if.alu_rs + alu_if.alu_rt) : 16'hA5A5;

  mul_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu     (alu_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode 0 idle, 1 running at bit index m_idx, 2 done.
  int           m_mode = 0;
  int           m_idx = 0;
  int           m_n = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_prod = '0;
  bit           m_clean = 1'b1;
  bit           chk_on = 1'b0;

  function automatic int top_bits(logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // a * (low idx bits of b), modulo 2^16
  function automatic logic [15:0] partial(logic [15:0] aa, logic [15:0] bb, int idx);
    logic [31:0] mask, p;
    mask = (32'd1 << idx) - 32'd1;
    p = {16'd0, aa} * {16'd0, (bb & mask[15:0])};
    return p[15:0];
  endfunction

  function automatic logic [15:0] shl(logic [15:0] aa, int n);
    logic [31:0] t;
    t = {16'd0, aa} << n;
    return t[15:0];
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_mode = 0; m_prod = '0; m_clean = 1'b1;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_a = a_i; m_b = b_i; m_clean = 1'b0; m_idx = 0;
          if (a_i == 0 || b_i == 0) begin
            m_n = 0; m_mode = 2; m_prod = '0;
          end else begin
            m_n = top_bits(b_i); m_mode = 1;
          end
        end
        1: if (!(m_b[m_idx] && !gnt)) begin
          m_idx++;
          if (m_idx == m_n) begin
            m_mode = 2;
            m_prod = partial(m_a, m_b, 16);
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    bit exp_req;
    exp_req = (m_mode == 1) ? m_b[m_idx] : 1'b0;
    cmp("busy", 32'(busy), 32'(m_mode != 0));
    cmp("done", 32'(done), 32'(m_mode == 2));
    cmp("product", 32'(product), 32'(m_prod));
    cmp("alu_req", 32'(alu_if.alu_req), 32'(exp_req));
    cmp("alu_opcode", 32'(alu_if.alu_opcode), 32'(5'b11011));
    cmp("alu_funct", 32'(alu_if.alu_funct), 32'(2'b00));
    if (m_mode == 1) begin
      cmp("alu_rs run", 32'(alu_if.alu_rs), 32'(partial(m_a, m_b, m_idx)));
      cmp("alu_rt run", 32'(alu_if.alu_rt), 32'(shl(m_a, m_idx)));
    end else if (m_mode == 2) begin
      cmp("alu_rs done", 32'(alu_if.alu_rs), 32'(partial(m_a, m_b, 16)));
      cmp("alu_rt done", 32'(alu_if.alu_rt), 32'(shl(m_a, m_n)));
    end else if (m_clean) begin
      cmp("alu_rs reset", 32'(alu_if.alu_rs), 32'd0);
      cmp("alu_rt reset", 32'(alu_if.alu_rt), 32'd0);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    if (chk_on) check_outputs();
  endtask

  // Runs one multiply. deny: number of requested cycles refused first.
  // rnd: random grants and random ignored starts while running.
  task automatic run_op(input logic [15:0] aa, input logic [15:0] bb, input int deny,
                        input int exp_lat, input logic [15:0] exp_prod,
                        input bit mid, input bit rnd, input string nm);
    int guard, lat, dl;
    dl = deny;
    guard = 0;
    while (busy && guard < 40) begin
      gnt = 1'b1; tick(); guard++;
    end
    a_i = aa; b_i = bb; start = 1'b1; gnt = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      start = 1'b0;
      if (mid && lat == 2) begin
        start = 1'b1; a_i = 16'h1234; b_i = 16'h0F0F;
      end
      if (rnd) begin
        gnt = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) begin
          start = 1'b1; a_i = 16'($urandom); b_i = 16'($urandom);
        end
      end else if (alu_if.alu_req && dl > 0) begin
        gnt = 1'b0; dl--;
      end else begin
        gnt = 1'b1;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    gnt = 1'b1;
    cmp({nm, " done seen"}, 32'(done), 32'd1);
    if (exp_lat >= 0) cmp({nm, " latency"}, 32'(lat), 32'(exp_lat));
    cmp({nm, " product"}, 32'(product), 32'(exp_prod));
  endtask

  initial begin
    int ndone;
    logic [15:0] ra, rb;
    logic [31:0] full;

    rst_n = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    cmp("reset busy", 32'(busy), 32'd0);
    cmp("reset done", 32'(done), 32'd0);
    cmp("reset product", 32'(product), 32'd0);
    cmp("reset alu_req", 32'(alu_if.alu_req), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(16'd3,    16'd5,    0, 4,  16'h000F, 1'b0, 1'b0, "3x5");
    run_op(16'hFFFF, 16'hFFFF, 0, 17, 16'h0001, 1'b0, 1'b0, "ffff_x_ffff");
    run_op(16'h0100, 16'h0100, 0, 10, 16'h0000, 1'b0, 1'b0, "overflow");
    run_op(16'd7,    16'd0,    0, 1,  16'h0000, 1'b0, 1'b0, "b_zero");
    run_op(16'd0,    16'd9,    0, 1,  16'h0000, 1'b0, 1'b0, "a_zero");
    run_op(16'd3,    16'd5,    2, 6,  16'h000F, 1'b0, 1'b0, "3x5_deny2");
    run_op(16'd3,    16'd5,    0, 4,  16'h000F, 1'b1, 1'b0, "3x5_mid_start");
    run_op(16'h0010, 16'h0003, 0, 3,  16'h0030, 1'b0, 1'b0, "back_to_back");
    run_op(16'h0001, 16'h8000, 0, 17, 16'h8000, 1'b0, 1'b0, "b_msb");

    // Reset in the middle of RUN: abandoned, no done afterwards.
    while (busy) begin gnt = 1'b1; tick(); end
    a_i = 16'd3; b_i = 16'h00FF; start = 1'b1; gnt = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cmp("midrst busy", 32'(busy), 32'd0);
    cmp("midrst done", 32'(done), 32'd0);
    cmp("midrst product", 32'(product), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    cmp("midrst no done", 32'(ndone), 32'd0);

    for (int t = 0; t < 60; t++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'd0;
        1: rb = 16'(1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) ra = 16'd0;
      full = {16'd0, ra} * {16'd0, rb};
      run_op(ra, rb, 0, -1, full[15:0], 1'b0, 1'b1, "random");
    end

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative 16x16 multiply sequencer that time-shares the execute-stage ALU. It runs shift-and-add over up to 16 iterations. All additions go through the shared ALU, borrowed for one cycle at a time with a request/grant handshake. The execute stage keeps priority. The decode stage stalls on `busy`; the 16-bit result goes to writeback on `done`.

## Interface
Parameters:
- `WIDTH`, 16, operand/product width
- `CNT_W`, 5, iteration counter width (must hold `WIDTH`)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin multiply; sampled only in IDLE
- `a`  in  WIDTH  multiplicand, sampled with `start`
- `b`  in  WIDTH  multiplier, sampled with `start`
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse, product valid
- `product`  out  WIDTH  low WIDTH bits of a*b, held until next accepted `start`
- `alu_req`  out  1  request ALU this cycle
- `alu_gnt`  in  1  ALU mux routes sequencer operands this cycle
- `alu_opcode`  out  5  driven 5'b11011 (R-type)
- `alu_funct`  out  2  driven 2'b00 (ADD)
- `alu_rs`  out  WIDTH  accumulator
- `alu_rt`  out  WIDTH  shifted multiplicand
- `alu_res`  in  WIDTH  combinational ALU result, valid when `alu_gnt`

## Operation
- Registers: `acc`, `mcand`, `mplier`, `cnt`, `product`, `state`.
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start`, load `acc`=0, `mcand`=a, `mplier`=b, `cnt`=0.
  - If b==0 or a==0, go to DONE with `acc`=0. Otherwise go to RUN.
- RUN, one iteration per cycle:
  - `mplier[0]`==1: assert `alu_req`. If `alu_gnt`=1, set `acc`<=`alu_res`, then shift. If `alu_gnt`=0, hold all registers and keep requesting.
  - `mplier[0]`==0: no request; shift only.
  - Shift: `mcand`<=`mcand`<<1, `mplier`<=`mplier`>>1, `cnt`<=`cnt`+1.
  - Exit to DONE when the post-shift `mplier`==0 or `cnt`==WIDTH-1 is completing.
- DONE: `product`<=final `acc` (registered on DONE entry), `done`=1 for one cycle, then return to IDLE.
- `alu_req` is high only in RUN with `mplier[0]`==1. `alu_opcode`/`alu_funct` are constant. `alu_rs`/`alu_rt` mirror `acc`/`mcand` at all times.
- Arithmetic is modulo 2^WIDTH; carry-out is ignored. The low bits are correct for both signed and unsigned operands.
- `start` in RUN/DONE is ignored; no queueing.
- `alu_gnt` without `alu_req` is ignored. `alu_res` is not sampled when a request is denied.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE; `busy`=0, `done`=0, `product`=0, `alu_req`=0, all internal registers 0.
  - Applies mid-operation: the operation is abandoned with no `done`.
- `start` accepted at edge k:
  - `busy`=1 from cycle k+1.
  - Minimum latency, full grant: `done` at cycle k+1+N, where N = index of the highest set bit of b, plus 1.
  - Each denied grant adds one cycle.
  - Zero operand: `done` at cycle k+1.
- Maximum latency, full grant: 17 cycles (b[15]=1).
- `done` and `busy` drop together the cycle after DONE. `start` may be accepted in that IDLE cycle.
- `product` updates only on DONE entry. It is stable between `done` pulses.

## Structure
- Shared package `alu_pkg`:
  - `ALU_OP_RTYPE`=5'b11011, `ALU_FN_ADD`=2'b00.
  - The `mul_state_t` enum (IDLE/RUN/DONE).
- The ALU-side request/grant mux lives in the execute stage, not here.
- One natural sub-module: `mul_seq_dp`. It holds `acc`/`mcand`/`mplier`/`cnt` with load/shift/update enables, driven by the FSM in `mul_seq`.

## Test plan
- a=3, b=5, `alu_gnt` tied 1, start at cycle 0 -> two ALU requests; `done` at cycle 4; `product`=0x000F.
- a=0xFFFF, b=0xFFFF, full grant -> 16 requests; `done` at cycle 17; `product`=0x0001.
- a=0x0100, b=0x0100 -> `product`=0x0000 (overflow wraps); a=7, b=0 -> `done` at cycle 1, `product`=0.
- a=3, b=5 with `alu_gnt` low for 2 cycles on the first request -> registers hold, `alu_req` stays high; `done` at cycle 6; `product`=0x000F.
- `start` pulsed mid-RUN with new operands -> ignored; original product returned. Back-to-back start in the IDLE cycle after `done` -> accepted.
- rst_n=0 during RUN cycle 2 -> next cycle IDLE, `busy`=0, `product`=0, no `done` pulse.
